// File: rtl/writeback_unit.sv
// Writeback stage: round-robin merge of ALU and memory results into the register
// file write port, plus a per-register pending-write scoreboard for hazard detection.
module writeback_unit #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int RW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [RW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [RW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  output logic [RW-1:0]   rf_sel_rd,
  output logic [XLEN-1:0] rf_in_rd,
  output logic            rf_we,
  input  logic            issue_valid,
  input  logic [RW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic [RW-1:0]   sel_rs1,
  input  logic [RW-1:0]   sel_rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [NREG-1:0] busy_vec
);

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  grant_e          last_grant_q, last_grant_d;
  logic            rf_we_q, rf_we_d;
  logic [RW-1:0]   rf_sel_rd_q, rf_sel_rd_d;
  logic [XLEN-1:0] rf_in_rd_q, rf_in_rd_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            rs1_busy_q, rs1_busy_d;
  logic            rs2_busy_q, rs2_busy_d;

  // Arbitration: on a conflict the source not granted last time wins.
  always_comb begin
    alu_ready    = 1'b0;
    mem_ready    = 1'b0;
    last_grant_d = last_grant_q;
    if (rst) begin
      alu_ready = 1'b0;
      mem_ready = 1'b0;
    end else begin
      alu_ready = alu_valid && !(mem_valid && (last_grant_q == GRANT_ALU));
      mem_ready = mem_valid && !(alu_valid && (last_grant_q == GRANT_MEM));
      if (alu_valid && mem_valid) begin
        last_grant_d = mem_ready ? GRANT_MEM : GRANT_ALU;
      end else begin
        last_grant_d = last_grant_q;
      end
    end
  end

  // Output register: x0 results complete the handshake but never raise the write enable.
  always_comb begin
    rf_we_d     = 1'b0;
    rf_sel_rd_d = rf_sel_rd_q;
    rf_in_rd_d  = rf_in_rd_q;
    if (alu_ready) begin
      rf_sel_rd_d = alu_rd;
      rf_in_rd_d  = alu_data;
      rf_we_d     = (alu_rd != {RW{1'b0}});
    end else if (mem_ready) begin
      rf_sel_rd_d = mem_rd;
      rf_in_rd_d  = mem_data;
      rf_we_d     = (mem_rd != {RW{1'b0}});
    end else begin
      rf_we_d = 1'b0;
    end
  end

  // Scoreboard: clear on the committing edge, then set; a same-edge set wins.
  always_comb begin
    issue_ready = rst || !busy_q[issue_rd] || (issue_rd == {RW{1'b0}});
    busy_d      = busy_q;
    if (rf_we_q) begin
      busy_d[rf_sel_rd_q] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (issue_valid && issue_ready && (issue_rd != {RW{1'b0}})) begin
      busy_d[issue_rd] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0]  = 1'b0;
    rs1_busy_d = busy_q[sel_rs1];
    rs2_busy_d = busy_q[sel_rs2];
  end

  // State registers with synchronous reset; reset drops any in-flight write.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GRANT_ALU;
      rf_we_q      <= 1'b0;
      rf_sel_rd_q  <= {RW{1'b0}};
      rf_in_rd_q   <= {XLEN{1'b0}};
      busy_q       <= {NREG{1'b0}};
      rs1_busy_q   <= 1'b0;
      rs2_busy_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_sel_rd_q  <= rf_sel_rd_d;
      rf_in_rd_q   <= rf_in_rd_d;
      busy_q       <= busy_d;
      rs1_busy_q   <= rs1_busy_d;
      rs2_busy_q   <= rs2_busy_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_sel_rd = rf_sel_rd_q;
  assign rf_in_rd  = rf_in_rd_q;
  assign busy_vec  = busy_q;
  assign rs1_busy  = rs1_busy_q;
  assign rs2_busy  = rs2_busy_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Table-driven bench for writeback_unit: per-cycle vectors with expected handshakes and
// scoreboard state; granted results are queued and compared when the write port shows them.
module tb_writeback_unit;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, mem_valid, issue_valid;
  logic [4:0]      alu_rd, mem_rd, issue_rd, sel_rs1, sel_rs2;
  logic [XLEN-1:0] alu_data, mem_data;
  logic            alu_ready, mem_ready, issue_ready;
  logic [4:0]      rf_sel_rd;
  logic [XLEN-1:0] rf_in_rd;
  logic            rf_we, rs1_busy, rs2_busy;
  logic [NREG-1:0] busy_vec;

  writeback_unit #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_sel_rd(rf_sel_rd), .rf_in_rd(rf_in_rd), .rf_we(rf_we),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .sel_rs1(sel_rs1), .sel_rs2(sel_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic        mv;  logic [4:0] mrd; logic [31:0] md;
    logic        iv;  logic [4:0] ird;
    logic [4:0]  rs1; logic [4:0] rs2;
    logic        ear; logic emr; logic eir;
    logic [31:0] ebusy;
    logic        ers1; logic ers2;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  sel;
    logic [31:0] data;
  } wb_t;

  vec_t        vecs[$];
  wb_t         wb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [4:0]  hold_sel;
  logic [31:0] hold_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                              input logic iv, input logic [4:0] ird,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic ear, input logic emr, input logic eir,
                              input logic [31:0] ebusy, input logic ers1, input logic ers2);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.mv = mv; v.mrd = mrd; v.md = md;
    v.iv = iv; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
    v.ear = ear; v.emr = emr; v.eir = eir; v.ebusy = ebusy; v.ers1 = ers1; v.ers2 = ers2;
    return v;
  endfunction

  task automatic check_wb(input string tag);
    wb_t e;
    if (wb_q.size() > 0) begin
      e = wb_q.pop_front();
      chk({tag, " rf_we"}, rf_we, e.we);
      chk({tag, " rf_sel_rd"}, rf_sel_rd, e.sel);
      chk({tag, " rf_in_rd"}, rf_in_rd, e.data);
      hold_sel  = e.sel;
      hold_data = e.data;
    end else begin
      chk({tag, " rf_we idle"}, rf_we, 1'b0);
      chk({tag, " rf_sel_rd hold"}, rf_sel_rd, hold_sel);
      chk({tag, " rf_in_rd hold"}, rf_in_rd, hold_data);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    wb_t   e;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
    mem_valid = v.mv; mem_rd = v.mrd; mem_data = v.md;
    issue_valid = v.iv; issue_rd = v.ird; sel_rs1 = v.rs1; sel_rs2 = v.rs2;
    #3;
    chk({tag, " alu_ready"}, alu_ready, v.ear);
    chk({tag, " mem_ready"}, mem_ready, v.emr);
    chk({tag, " issue_ready"}, issue_ready, v.eir);
    if (v.ear) begin
      e.we = (v.ard != 5'd0); e.sel = v.ard; e.data = v.ad;
      wb_q.push_back(e);
    end else if (v.emr) begin
      e.we = (v.mrd != 5'd0); e.sel = v.mrd; e.data = v.md;
      wb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    chk({tag, " busy_vec"}, busy_vec, v.ebusy);
    chk({tag, " rs1_busy"}, rs1_busy, v.ers1);
    chk({tag, " rs2_busy"}, rs2_busy, v.ers2);
    check_wb(tag);
  endtask

  task automatic reset_cycle(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #3;
    chk({tag, " alu_ready"}, alu_ready, 1'b0);
    chk({tag, " mem_ready"}, mem_ready, 1'b0);
    chk({tag, " issue_ready"}, issue_ready, 1'b1);
    @(posedge clk);
    #1;
    chk({tag, " rf_we"}, rf_we, 1'b0);
    chk({tag, " rf_sel_rd"}, rf_sel_rd, 5'd0);
    chk({tag, " rf_in_rd"}, rf_in_rd, 32'd0);
    chk({tag, " busy_vec"}, busy_vec, 32'd0);
    chk({tag, " rs1_busy"}, rs1_busy, 1'b0);
    chk({tag, " rs2_busy"}, rs2_busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1111_1111;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h2222_2222;
    issue_valid = 1'b1; issue_rd = 5'd5; sel_rs1 = 5'd5; sel_rs2 = 5'd5;
    hold_sel = 5'd0; hold_data = 32'd0;

    // Idle / issue / ALU write of x5 with stale-read tracking on rs1.
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0));
    // Conflicts alternate mem, alu, mem, alu; losers hold their result.
    vecs.push_back(mk(1'b1, 5'd10, 32'hA0, 1'b1, 5'd20, 32'hB0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 5'd10, 32'hA0, 1'b1, 5'd21, 32'hB1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 5'd11, 32'hA1, 1'b1, 5'd21, 32'hB1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 5'd11, 32'hA1, 1'b1, 5'd22, 32'hB2, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0));
    // Lone grants leave the round-robin pointer alone.
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd22, 32'hB2, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 5'd12, 32'hA2, 1'b1, 5'd23, 32'hB3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 5'd12, 32'hA2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 5'd13, 32'hA3, 1'b1, 5'd24, 32'hB4, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd24, 32'hB4, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0));
    // x0 write: handshake completes, no write enable.
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0));
    // Stale read of x7 on both read ports.
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0));
    // WAW stall on x3; x0 issue never stalls nor sets.
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h08, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h08, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h08, 1'b0, 1'b0));
    // Same-edge set and clear on x9: set wins.
    vecs.push_back(mk(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 32'h208, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 32'h208, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 32'h200, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0));

    // Reset held two cycles with both sources valid.
    reset_cycle("rst0");
    reset_cycle("rst1");
    rst = 1'b0;
    alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Mid-run reset while x4 is being written and x9 is busy.
    alu_valid = 1'b1; alu_rd = 5'd6; mem_valid = 1'b1; issue_valid = 1'b1; issue_rd = 5'd9;
    sel_rs1 = 5'd9;
    reset_cycle("rst_mid");
    rst = 1'b0;
    hold_sel = 5'd0; hold_data = 32'd0;
    // After reset the first conflict goes to mem.
    apply(mk(1'b1, 5'd1, 32'hC1, 1'b1, 5'd2, 32'hC2, 1'b0, 5'd0, 5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0), 100);
    apply(mk(1'b1, 5'd1, 32'hC1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0), 101);
    apply(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0), 102);
    chk("scoreboard queue drained", wb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
